// File: rtl/data_mem_responder_if.sv
// Bus between the memory control unit (master) and the data memory responder (slave):
// req/ready handshake, read/write select, 16-bit word address, 32-bit data both ways.
interface data_mem_responder_if;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, rw, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, rw, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: DEPTH x 32 array serving LDR/STR over a req/ready handshake.
// Define MEM_WAIT_EN to compile in the WAIT state and its counter (WAIT_CYCLES wait states).
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef MEM_WAIT_EN
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam bit         USE_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`else
    localparam bit         USE_WAIT  = 1'b0;
`endif

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_reg, state_next;
    logic        rw_reg;
    logic [15:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        ready_reg;
    logic        err_reg;
`ifdef MEM_WAIT_EN
    logic [3:0]  wait_cnt_reg;
`endif

    logic          accept;
    logic          wait_done;
    logic          enter_resp;
    logic          txn_rw;
    logic [15:0]   txn_addr;
    logic [31:0]   txn_wdata;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic          mem_we;

    assign accept = (state_reg == ST_IDLE) && bus.req;
`ifdef MEM_WAIT_EN
    assign wait_done = (state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0);
`else
    assign wait_done = 1'b0;
`endif
    assign enter_resp = (accept && !USE_WAIT) || wait_done;

    // Without wait states the commit happens on the accept edge, so bypass the capture registers.
    assign txn_rw    = accept ? bus.rw    : rw_reg;
    assign txn_addr  = accept ? bus.addr  : addr_reg;
    assign txn_wdata = accept ? bus.wdata : wdata_reg;
    assign in_range  = ({1'b0, txn_addr} < DEPTH_L);
    assign mem_idx   = txn_addr[AW-1:0];
    // Gate with rst_n so a request seen while reset is held can never commit.
    assign mem_we    = enter_resp && txn_rw && in_range && rst_n;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
`ifdef MEM_WAIT_EN
                    state_next = USE_WAIT ? ST_WAIT : ST_RESP;
`else
                    state_next = ST_RESP;
`endif
                end
            end
`ifdef MEM_WAIT_EN
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_RESP;
                end
            end
`endif
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Array has no reset so it maps onto block RAM; committed contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= txn_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            rw_reg    <= 1'b0;
            addr_reg  <= 16'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rw_reg    <= bus.rw;
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
            end
            ready_reg <= enter_resp;
            err_reg   <= enter_resp && !in_range;
            if (enter_resp) begin
                if (!in_range) begin
                    rdata_reg <= 32'd0;
                end else if (!txn_rw) begin
                    rdata_reg <= mem[mem_idx];
                end
            end
        end
    end

`ifdef MEM_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= 4'd0;
        end else if (accept) begin
            wait_cnt_reg <= WAIT_LOAD;
        end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
    end
`endif

    assign bus.rdata = rdata_reg;
    assign bus.ready = ready_reg;
    assign bus.err   = err_reg;

endmodule
